// File: rtl/final_bits_pkg.sv
// Shared types and constants for the end-of-frame final-bits flush sequencer.
package final_bits_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} fb_state_e;

    localparam int S_BASE   = 10;
    localparam int C_BASE   = 7;
    localparam int STEP     = 8;
    localparam int S_THRESH = 9;

    // Low-order mask that the final rounding step clears.
    function automatic logic [63:0] m_mask(input int low_width);
        return (64'd1 << (low_width - 10)) - 64'd1;
    endfunction

endpackage

// File: rtl/final_bits_flush_seq_word_extract.sv
// Combinational word slicer: picks the word above bit c and keeps only the bits below it.
module final_bits_word_extract #(
    parameter int EW = 25,
    parameter int CW = 7,
    parameter int OW = 16
) (
    input  logic [EW-1:0]        e_i,
    input  logic signed [CW-1:0] c_i,
    output logic [OW-1:0]        word_o,
    output logic [EW-1:0]        e_next_o
);

    // c is never negative on the emit path, so treat it as a plain shift amount.
    logic [CW-1:0] sh;
    logic [EW-1:0] keep_mask;

    assign sh        = c_i;
    assign keep_mask = ({{(EW-1){1'b0}}, 1'b1} << sh) - {{(EW-1){1'b0}}, 1'b1};
    assign word_o    = OW'(e_i >> sh);
    assign e_next_o  = e_i & keep_mask;

endmodule

// File: rtl/final_bits_flush_seq.sv
// End-of-frame flush: latches final low/cnt, then streams the remaining final words
// over a valid/ready port with the last word tagged.
module final_bits_flush_seq
    import final_bits_pkg::*;
#(
    parameter int OUTPUT_BITSTREAM_WIDTH = 16,
    parameter int D_SIZE                 = 5,
    parameter int LOW_WIDTH              = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_req,
    input  logic [LOW_WIDTH-1:0]              in_low,
    input  logic [D_SIZE-1:0]                 in_cnt,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_word,
    output logic                              out_last,
    output logic                              done
);

    localparam int EW = LOW_WIDTH + 1;
    localparam int CW = D_SIZE + 2;
    localparam logic [EW-1:0] M = EW'(m_mask(LOW_WIDTH));

    fb_state_e                   state_q, state_d;
    logic [LOW_WIDTH-1:0]        low_q, low_d;
    logic signed [CW-1:0]        cnt_q, cnt_d;
    logic [EW-1:0]               e_q, e_d;
    logic signed [CW-1:0]        c_q, c_d;
    logic signed [CW-1:0]        s_q, s_d;

    logic [EW-1:0]               low_sum, e_load, e_next;
    logic signed [CW-1:0]        s_load, s_m8;
    logic [OUTPUT_BITSTREAM_WIDTH-1:0] word;
    logic                        last;

    // The carry out of low+m lands in bit LOW_WIDTH and is kept.
    assign low_sum = {1'b0, low_q} + M;
    assign e_load  = (low_sum & ~M) | (M + {{(EW-1){1'b0}}, 1'b1});
    assign s_load  = cnt_q + CW'(S_BASE);
    assign s_m8    = s_q - CW'(STEP);
    assign last    = (s_m8 <= CW'(S_THRESH));

    final_bits_word_extract #(
        .EW(EW),
        .CW(CW),
        .OW(OUTPUT_BITSTREAM_WIDTH)
    ) u_extract (
        .e_i     (e_q),
        .c_i     (c_q),
        .word_o  (word),
        .e_next_o(e_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            low_q   <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            c_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            c_q     <= c_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        c_d     = c_q;
        s_d     = s_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    low_d   = in_low;
                    cnt_d   = {{2{in_cnt[D_SIZE-1]}}, in_cnt};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                e_d     = e_load;
                c_d     = cnt_q + CW'(C_BASE);
                s_d     = s_load;
                state_d = (s_load > CW'(S_THRESH)) ? EMIT : DONE;
            end
            EMIT: begin
                if (out_ready) begin
                    e_d = e_next;
                    c_d = c_q - CW'(STEP);
                    s_d = s_m8;
                    if (last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them immediately.
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_last  = out_valid & last;
    assign out_word  = out_valid ? word : '0;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_final_bits_flush_seq.sv
// Scoreboarded bench for the final-bits flush sequencer with a spec-level word model.
module tb_final_bits_flush_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_req;
    logic [23:0] in_low;
    logic [4:0]  in_cnt;
    logic        busy, out_valid, out_ready, out_last, done;
    logic [15:0] out_word;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    int done_count = 0;
    int mode = 0;
    int stall = 0;
    logic [16:0] exp_q[$];

    bit          prev_stall = 0;
    logic [15:0] pw;
    logic        pl;

    final_bits_flush_seq #(
        .OUTPUT_BITSTREAM_WIDTH(16),
        .D_SIZE(5),
        .LOW_WIDTH(24)
    ) dut (
        .clk(clk), .reset(reset), .flush_req(flush_req), .in_low(in_low), .in_cnt(in_cnt),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Consumer: 0 = always ready, 1 = random, 2 = hold each word off for 3 cycles.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (out_valid && stall < 3) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    stall = 0;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: pops expectations on handshakes, checks hold-stability during stalls.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!out_valid || out_word !== pw || out_last !== pl) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b w=%h l=%0b want v=1 w=%h l=%0b",
                             out_valid, out_word, out_last, pw, pl);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got w=%h l=%0b want none", out_word, out_last);
                end else begin
                    logic [16:0] ex;
                    ex = exp_q.pop_front();
                    if ({out_word, out_last} !== ex) begin
                        bad++;
                        $display("FAIL word: got w=%h l=%0b want w=%h l=%0b",
                                 out_word, out_last, ex[16:1], ex[0]);
                    end
                end
                hs_count++;
            end
            if (done) done_count++;
            prev_stall = out_valid && !out_ready;
            pw = out_word;
            pl = out_last;
        end
    end

    task automatic check(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    // Reference: round low up to the mask boundary, set the stop bit, then peel
    // 8-bit-step words off the top while more than 9 bits of state remain.
    function automatic int model_push(input logic [23:0] low, input logic [4:0] cnt);
        longint unsigned m, e;
        int c, s, n;
        logic [15:0] w;
        m = (64'd1 << 14) - 1;
        e = ((longint'(low) + m) & ~m) | (m + 1);
        c = int'($signed(cnt)) + 7;
        s = int'($signed(cnt)) + 10;
        n = 0;
        while (s > 9) begin
            w = 16'(e >> c);
            exp_q.push_back({w, (s - 8 <= 9)});
            e = e & ((longint'(1) << c) - 1);
            c -= 8;
            s -= 8;
            n++;
        end
        return n;
    endfunction

    task automatic flush(input logic [23:0] low, input logic [4:0] cnt, input int exp_n);
        int hs0, d0;
        bit got;
        hs0 = hs_count;
        d0  = done_count;
        flush_req = 1'b1; in_low = low; in_cnt = cnt;
        @(posedge clk); #1;
        flush_req = 1'b0; in_low = $urandom; in_cnt = 5'($urandom);
        check("busy_after_accept", busy, 1);
        @(posedge clk); #1;
        check("first_valid_cycle2", out_valid, (exp_n > 0) ? 1 : 0);
        check("done_cycle2", done, (exp_n == 0) ? 1 : 0);
        // Busy (EMIT or DONE): this request must be ignored.
        flush_req = 1'b1; in_low = $urandom; in_cnt = 5'($urandom);
        @(posedge clk); #1;
        flush_req = 1'b0;
        got = 0;
        for (int k = 0; k < 300; k++) begin
            if (done_count > d0) begin
                got = 1;
                break;
            end
            @(negedge clk); #1;
        end
        check("done_seen", got, 1);
        check("handshakes", hs_count - hs0, exp_n);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check("busy_low_after", busy, 0);
        check("done_once", done_count - d0, 1);
        check("valid_low_after", out_valid, 0);
    endtask

    initial begin
        int n;
        logic [23:0] rl;
        logic [4:0]  rc;
        reset = 1'b1; flush_req = 1'b0; in_low = '0; in_cnt = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_word", out_word, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        mode = 0;
        exp_q.push_back({16'h0080, 1'b1});
        flush(24'h000000, 5'd0, 1);

        exp_q.push_back({16'h0024, 1'b0});
        exp_q.push_back({16'h0080, 1'b1});
        flush(24'h123456, 5'd8, 2);

        flush(24'($urandom), 5'h1F, 0);

        mode = 2;
        exp_q.push_back({16'h0024, 1'b0});
        exp_q.push_back({16'h0080, 1'b1});
        flush(24'h123456, 5'd8, 2);
        mode = 0;

        exp_q.push_back({16'h0200, 1'b0});
        exp_q.push_back({16'h0080, 1'b1});
        flush(24'hFFFFFF, 5'd8, 2);

        // Reset while the first word of a flush is stalled.
        mode = 2;
        flush_req = 1'b1; in_low = 24'h123456; in_cnt = 5'd8;
        @(posedge clk); #1;
        flush_req = 1'b0;
        n = 0;
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_valid", out_valid, 1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_word", out_word, 0);
        check("async_rst_last", out_last, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mode = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_valid", out_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        exp_q.push_back({16'h0080, 1'b1});
        flush(24'h000000, 5'd0, 1);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            rl = 24'($urandom);
            rc = 5'($urandom);
            n = model_push(rl, rc);
            flush(rl, rc, n);
        end
        mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
